// File: rtl/crc_pkg.sv
// Shared constants, state type and keep helper for the streaming CRC-32 frame checker.
package crc_pkg;

    localparam int unsigned CRC_W       = 32;
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;

    typedef enum logic {
        IDLE,
        IN_FRAME
    } crc_chk_state_e;

    // Number of set bits in a byte-enable mask, for beats of up to 16 bytes.
    function automatic logic [4:0] popcount_keep(input logic [15:0] keep);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(keep[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One byte of CRC-32 update: bits enter LSB first into a left-shifting register.
module crc_byte_step
    import crc_pkg::*;
(
    input  logic [CRC_W-1:0] crc_cur,
    input  logic [7:0]       byte_data,
    output logic [CRC_W-1:0] crc_next
);

    always_comb begin
        crc_next = crc_cur;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[CRC_W-1] ^ byte_data[i]) begin
                crc_next = {crc_next[CRC_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                crc_next = {crc_next[CRC_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/crc_stream_checker.sv
// Streaming Ethernet FCS checker: per-beat CRC-32 over a partial-keep datapath,
// registered per-frame status (crc ok, runt, keep error, length).
module crc_stream_checker
    import crc_pkg::*;
#(
    parameter int unsigned BYTES           = 8,
    parameter int unsigned MIN_FRAME_BYTES = 64,
    parameter int unsigned LEN_W           = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               s_valid_i,
    input  logic [BYTES*8-1:0] s_data_i,
    input  logic [BYTES-1:0]   s_keep_i,
    input  logic               s_last_i,
    input  logic               s_abort_i,
    output logic               done_o,
    output logic               crc_ok_o,
    output logic               runt_o,
    output logic               keep_err_o,
    output logic [LEN_W-1:0]   frame_len_o
);

    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_FRAME_BYTES);

    crc_chk_state_e   state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_q, err_d;
    logic             emit;

    logic             done_q, ok_q, runt_q, kerr_q;
    logic [LEN_W-1:0] flen_q;

    // The first beat of a frame starts from fresh state, whatever the registers hold.
    logic [CRC_W-1:0] crc_base;
    logic [LEN_W-1:0] len_base;
    logic             err_base;

    assign crc_base = (state_q == IDLE) ? CRC_INIT : crc_q;
    assign len_base = (state_q == IDLE) ? '0 : len_q;
    assign err_base = (state_q == IDLE) ? 1'b0 : err_q;

    logic [4:0]       keep_cnt;
    logic [BYTES-1:0] keep_plus1;
    logic             keep_legal;

    assign keep_cnt   = popcount_keep(16'(s_keep_i));
    assign keep_plus1 = s_keep_i + BYTES'(1);
    assign keep_legal = (s_keep_i != '0) && ((s_keep_i & keep_plus1) == '0) &&
                        (s_last_i || (s_keep_i == '1));

    logic [CRC_W-1:0] stage_out [BYTES];

    for (genvar g = 0; g < BYTES; g++) begin : g_step
        logic [CRC_W-1:0] crc_in;
        logic [CRC_W-1:0] crc_out;
        if (g == 0) begin : g_first
            assign crc_in = crc_base;
        end else begin : g_chain
            assign crc_in = g_step[g-1].crc_out;
        end
        crc_byte_step u_step (
            .crc_cur  (crc_in),
            .byte_data(s_data_i[8*g +: 8]),
            .crc_next (crc_out)
        );
        assign stage_out[g] = crc_out;
    end

    logic [CRC_W-1:0] beat_crc;
    logic [LEN_W:0]   len_sum;
    logic [LEN_W-1:0] beat_len;
    logic             beat_err;

    // Pick the CRC after exactly popcount(keep) bytes, even for an illegal mask.
    always_comb begin
        beat_crc = crc_base;
        for (int k = 1; k <= int'(BYTES); k++) begin
            if (keep_cnt == 5'(k)) begin
                beat_crc = stage_out[k-1];
            end
        end
    end

    assign len_sum  = {1'b0, len_base} + (LEN_W+1)'(keep_cnt);
    assign beat_len = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    assign beat_err = err_base | ~keep_legal;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        len_d   = len_q;
        err_d   = err_q;
        emit    = 1'b0;
        if (s_abort_i) begin
            state_d = IDLE;
            crc_d   = CRC_INIT;
            len_d   = '0;
            err_d   = 1'b0;
        end else if (s_valid_i) begin
            if (s_last_i) begin
                state_d = IDLE;
                crc_d   = CRC_INIT;
                len_d   = '0;
                err_d   = 1'b0;
                emit    = 1'b1;
            end else begin
                state_d = IN_FRAME;
                crc_d   = beat_crc;
                len_d   = beat_len;
                err_d   = beat_err;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            crc_q   <= CRC_INIT;
            len_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            runt_q  <= 1'b0;
            kerr_q  <= 1'b0;
            flen_q  <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
            err_q   <= err_d;
            done_q  <= emit;
            if (emit) begin
                ok_q   <= (beat_crc == CRC_RESIDUE);
                runt_q <= (beat_len < MIN_LEN);
                kerr_q <= beat_err;
                flen_q <= beat_len;
            end
        end
    end

    assign done_o      = done_q;
    assign crc_ok_o    = ok_q;
    assign runt_o      = runt_q;
    assign keep_err_o  = kerr_q;
    assign frame_len_o = flen_q;

endmodule

// File: tb/tb_crc_stream_checker.sv
// Directed bench for crc_stream_checker: table of frames plus abort/back-to-back/reset sequences.
module tb_crc_stream_checker;

    typedef logic [7:0] byte_q_t[$];

    typedef struct {
        string       name;
        bit          use_check;
        int unsigned payload_len;
        bit          flip;
        int          keep_mode;
        logic        exp_ok;
        logic        exp_runt;
        logic        exp_kerr;
        logic [15:0] exp_len;
    } vec_t;

    typedef struct {
        logic        ok;
        logic        runt;
        logic        kerr;
        logic [15:0] len;
        int          cyc;
    } st_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0, s_last = 1'b0, s_abort = 1'b0;
    logic [63:0] s_data = '0;
    logic [7:0]  s_keep = '0;
    logic        done8, ok8, runt8, kerr8;
    logic [15:0] len8;

    logic        v1 = 1'b0, l1 = 1'b0, a1 = 1'b0;
    logic [7:0]  d1 = '0;
    logic [0:0]  k1 = '0;
    logic        done1, ok1, runt1, kerr1;
    logic [15:0] len1;

    int   cyc = 0;
    int   last_cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    st_t  st8_q[$];
    st_t  st1_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    crc_stream_checker #(.BYTES(8), .MIN_FRAME_BYTES(64), .LEN_W(16)) dut8 (
        .clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_data_i(s_data), .s_keep_i(s_keep),
        .s_last_i(s_last), .s_abort_i(s_abort), .done_o(done8), .crc_ok_o(ok8),
        .runt_o(runt8), .keep_err_o(kerr8), .frame_len_o(len8)
    );

    crc_stream_checker #(.BYTES(1), .MIN_FRAME_BYTES(64), .LEN_W(16)) dut1 (
        .clk_i(clk), .rst_i(rst), .s_valid_i(v1), .s_data_i(d1), .s_keep_i(k1),
        .s_last_i(l1), .s_abort_i(a1), .done_o(done1), .crc_ok_o(ok1),
        .runt_o(runt1), .keep_err_o(kerr1), .frame_len_o(len1)
    );

    always @(negedge clk) begin
        if (done8) st8_q.push_back('{ok: ok8, runt: runt8, kerr: kerr8, len: len8, cyc: cyc});
        if (done1) st1_q.push_back('{ok: ok1, runt: runt1, kerr: kerr1, len: len1, cyc: cyc});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reflected (right-shift) CRC-32 used only to build FCS bytes for stimulus.
    function automatic logic [31:0] crc32_ref(input byte_q_t q);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic byte_q_t build(input vec_t v);
        byte_q_t     q;
        logic [31:0] fcs;
        if (v.use_check) begin
            q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB};
        end else begin
            for (int i = 0; i < int'(v.payload_len); i++) q.push_back(8'(i * 7 + 3 + v.payload_len));
            fcs = crc32_ref(q);
            for (int b = 0; b < 4; b++) q.push_back(fcs[8*b +: 8]);
        end
        if (v.flip) q[0] = q[0] ^ 8'h01;
        return q;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0; s_last = 1'b0; s_abort = 1'b0; s_keep = '0; s_data = '0;
        end
    endtask

    // keep_mode 1: middle beat (index 3) carries 4 bytes; 2: last beat uses keep 8'h05.
    task automatic send_frame(input byte_q_t fr, input int keep_mode, input int abort_beat,
                              input bit gap);
        int          idx;
        int          beat;
        int          cnt;
        logic [8:0]  kk;
        logic        lst;
        idx  = 0;
        beat = 0;
        while (idx < fr.size()) begin
            cnt = (fr.size() - idx > 8) ? 8 : fr.size() - idx;
            if (keep_mode == 1 && beat == 3) cnt = 4;
            lst = (idx + cnt >= fr.size());
            kk  = (9'd1 << cnt) - 9'd1;
            @(negedge clk);
            s_data = '0;
            for (int b = 0; b < 8; b++) if (b < cnt) s_data[8*b +: 8] = fr[idx + b];
            s_keep  = (keep_mode == 2 && lst) ? 8'h05 : kk[7:0];
            s_valid = 1'b1;
            s_last  = lst;
            s_abort = (beat == abort_beat);
            if (lst) last_cyc = cyc;
            idx  += cnt;
            beat += 1;
            if (beat - 1 == abort_beat) break;
            if (gap && beat == 2 && !lst) idle(1);
        end
    endtask

    vec_t    vecs[7];
    byte_q_t fr;
    st_t     s;

    initial begin
        vecs[0] = '{"check13",    1, 0,   0, 0, 1, 1, 0, 16'd13};
        vecs[1] = '{"check13bad", 1, 0,   1, 0, 0, 1, 0, 16'd13};
        vecs[2] = '{"len64",      0, 60,  0, 0, 1, 0, 0, 16'd64};
        vecs[3] = '{"len63",      0, 59,  0, 0, 1, 1, 0, 16'd63};
        vecs[4] = '{"keepmid",    0, 60,  0, 1, 1, 0, 1, 16'd64};
        vecs[5] = '{"keeplast",   0, 62,  0, 2, 1, 0, 1, 16'd66};
        vecs[6] = '{"len104",     0, 100, 0, 0, 1, 0, 0, 16'd104};

        repeat (3) @(negedge clk);
        check("reset done", done8, 0);
        check("reset ok", ok8, 0);
        check("reset runt", runt8, 0);
        check("reset kerr", kerr8, 0);
        check("reset len", len8, 0);
        rst = 1'b0;
        idle(2);

        foreach (vecs[i]) begin
            st8_q.delete();
            fr = build(vecs[i]);
            send_frame(fr, vecs[i].keep_mode, -1, 1'b1);
            idle(3);
            check({vecs[i].name, " done count"}, st8_q.size(), 1);
            if (st8_q.size() > 0) begin
                s = st8_q.pop_front();
                check({vecs[i].name, " crc_ok"}, s.ok, vecs[i].exp_ok);
                check({vecs[i].name, " runt"}, s.runt, vecs[i].exp_runt);
                check({vecs[i].name, " keep_err"}, s.kerr, vecs[i].exp_kerr);
                check({vecs[i].name, " len"}, s.len, vecs[i].exp_len);
                check({vecs[i].name, " latency"}, s.cyc, last_cyc + 1);
            end
            check({vecs[i].name, " done low after"}, done8, 0);
            check({vecs[i].name, " len held"}, len8, vecs[i].exp_len);
        end

        // Back-to-back 64-byte frames with no idle beat in between.
        st8_q.delete();
        fr = build(vecs[2]);
        send_frame(fr, 0, -1, 1'b0);
        send_frame(fr, 0, -1, 1'b0);
        idle(3);
        check("b2b done count", st8_q.size(), 2);
        while (st8_q.size() > 0) begin
            s = st8_q.pop_front();
            check("b2b crc_ok", s.ok, 1);
            check("b2b runt", s.runt, 0);
            check("b2b len", s.len, 64);
        end

        // Abort on the last beat wins over valid&last; abort on 3rd beat drops the frame.
        st8_q.delete();
        send_frame(build(vecs[0]), 0, 1, 1'b0);
        idle(3);
        check("abort on last no done", st8_q.size(), 0);
        send_frame(fr, 0, 2, 1'b0);
        idle(2);
        send_frame(fr, 0, -1, 1'b0);
        idle(3);
        check("after abort done count", st8_q.size(), 1);
        if (st8_q.size() > 0) begin
            s = st8_q.pop_front();
            check("after abort crc_ok", s.ok, 1);
            check("after abort len", s.len, 64);
        end

        // Async reset in the middle of a frame.
        st8_q.delete();
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            s_valid = 1'b1; s_keep = 8'hFF; s_last = 1'b0;
            for (int j = 0; j < 8; j++) s_data[8*j +: 8] = fr[8*b + j];
        end
        @(negedge clk);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid reset ok", ok8, 0);
        check("mid reset len", len8, 0);
        check("mid reset done", done8, 0);
        #3 rst = 1'b0;
        idle(3);
        check("mid reset no done", st8_q.size(), 0);
        send_frame(fr, 0, -1, 1'b1);
        idle(3);
        check("post reset done count", st8_q.size(), 1);
        if (st8_q.size() > 0) begin
            s = st8_q.pop_front();
            check("post reset crc_ok", s.ok, 1);
            check("post reset len", s.len, 64);
        end

        // BYTES=1 instance, check-string frame.
        st1_q.delete();
        fr = build(vecs[0]);
        for (int i = 0; i < fr.size(); i++) begin
            @(negedge clk);
            v1 = 1'b1; d1 = fr[i]; k1 = 1'b1; l1 = (i == fr.size() - 1);
        end
        @(negedge clk);
        v1 = 1'b0; l1 = 1'b0; k1 = 1'b0; d1 = '0;
        idle(3);
        check("b1 done count", st1_q.size(), 1);
        if (st1_q.size() > 0) begin
            s = st1_q.pop_front();
            check("b1 crc_ok", s.ok, 1);
            check("b1 runt", s.runt, 1);
            check("b1 len", s.len, 13);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
